// File: rtl/csel_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csel_adder_pipe : two-stage pipelined carry-select adder/subtractor with    |
// |                   valid/ready handshake on both sides.                      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module csel_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NB = WIDTH / BLOCK;

  logic             adv;
  logic             xfer_in;
  logic [WIDTH-1:0] b_eff;

  logic [WIDTH-1:0] s0_d, s1_d;
  logic [NB-1:0]    c0_d, c1_d;
  logic             m0_d, m1_d;

  logic [WIDTH-1:0] s0_q, s1_q;
  logic [NB-1:0]    c0_q, c1_q;
  logic             cin_q, m0_q, m1_q;
  logic             v1_q, v2_q;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;

  assign adv      = !v2_q || out_ready;
  assign in_ready = adv;
  assign xfer_in  = in_valid && adv;
  assign b_eff    = sub ? ~B : B;

  // Each block ripples twice: once assuming carry-in 0, once assuming 1.
  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [BLOCK-1:0] bs0, bs1;
    logic             bc0, bc1;

    always_comb begin
      logic r0, r1, ai, bi;
      bs0 = '0;
      bs1 = '0;
      r0  = 1'b0;
      r1  = 1'b1;
      ai  = 1'b0;
      bi  = 1'b0;
      for (int i = 0; i < BLOCK; i++) begin
        ai     = A[k*BLOCK + i];
        bi     = b_eff[k*BLOCK + i];
        bs0[i] = ai ^ bi ^ r0;
        bs1[i] = ai ^ bi ^ r1;
        r0     = (ai & bi) | (r0 & (ai ^ bi));
        r1     = (ai & bi) | (r1 & (ai ^ bi));
      end
      bc0 = r0;
      bc1 = r1;
    end

    assign s0_d[k*BLOCK +: BLOCK] = bs0;
    assign s1_d[k*BLOCK +: BLOCK] = bs1;
    assign c0_d[k]                = bc0;
    assign c1_d[k]                = bc1;
  end

  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  assign m0_d = s0_d[WIDTH-1] ^ A[WIDTH-1] ^ b_eff[WIDTH-1];
  assign m1_d = s1_d[WIDTH-1] ^ A[WIDTH-1] ^ b_eff[WIDTH-1];

  always_ff @(posedge clk) begin
    if (xfer_in) begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      c0_q  <= c0_d;
      c1_q  <= c1_d;
      m0_q  <= m0_d;
      m1_q  <= m1_d;
      cin_q <= sub | Cin;
    end
  end

  always_comb begin
    logic [NB:0] sel;
    sel    = '0;
    sum_d  = '0;
    sel[0] = cin_q;
    for (int k = 0; k < NB; k++) begin
      sum_d[k*BLOCK +: BLOCK] = sel[k] ? s1_q[k*BLOCK +: BLOCK] : s0_q[k*BLOCK +: BLOCK];
      sel[k+1]                = sel[k] ? c1_q[k] : c0_q[k];
    end
    cout_d = sel[NB];
    ovf_d  = (sel[NB-1] ? m1_q : m0_q) ^ sel[NB];
  end

  // Results only load from a valid S1 so idle cycles leave outputs untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      if (v1_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign sum       = sum_q;
  assign Cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = v2_q;

endmodule
`default_nettype wire

// File: tb/tb_csel_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_csel_adder_pipe : directed and randomized checks of csel_adder_pipe.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_csel_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Directed instance (16-bit, 4-bit blocks)
  logic [15:0] d_a, d_b, d_sum;
  logic        d_cin, d_sub, d_iv, d_ir, d_cout, d_ovf, d_ov, d_or, d_rst;

  csel_adder_pipe #(.WIDTH(16), .BLOCK(4)) u_dut (
    .clk(clk), .reset(d_rst), .A(d_a), .B(d_b), .Cin(d_cin), .sub(d_sub),
    .in_valid(d_iv), .in_ready(d_ir), .sum(d_sum), .Cout(d_cout), .ovf(d_ovf),
    .out_valid(d_ov), .out_ready(d_or)
  );

  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic s, input logic [15:0] es,
                        input logic ec, input logic eo);
    @(posedge clk); #1;
    d_a = a; d_b = b; d_cin = cin; d_sub = s; d_iv = 1'b1;
    @(posedge clk); #1;
    d_iv = 1'b0; d_a = 16'h5A5A; d_b = 16'hA5A5;
    chk({nm, " valid_early"}, 64'(d_ov), 64'd0);
    @(posedge clk); #1;
    chk({nm, " valid"}, 64'(d_ov), 64'd1);
    chk({nm, " sum"},   64'(d_sum), 64'(es));
    chk({nm, " cout"},  64'(d_cout), 64'(ec));
    chk({nm, " ovf"},   64'(d_ovf), 64'(eo));
  endtask

  // Randomized instances over several width/block pairs
  logic rrst = 1'b1;

  for (genvar g = 0; g < 4; g++) begin : g_rand
    localparam int W  = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 32 : 12;
    localparam int BK = (g == 0) ? 1 : (g == 1) ? 4  : (g == 2) ? 8  : 12;

    logic [W-1:0] a = '0, b = '0, s;
    logic         cin = 1'b0, sb = 1'b0, iv = 1'b0, ordy = 1'b1;
    logic         ir, co, of, ov;
    logic         done = 1'b0;
    logic [W+1:0] q[$];
    logic [W+1:0] held = '0;
    logic         stalled = 1'b0;

    csel_adder_pipe #(.WIDTH(W), .BLOCK(BK)) u_r (
      .clk(clk), .reset(rrst), .A(a), .B(b), .Cin(cin), .sub(sb),
      .in_valid(iv), .in_ready(ir), .sum(s), .Cout(co), .ovf(of),
      .out_valid(ov), .out_ready(ordy)
    );

    // Integer-level reference: unsigned result for sum/Cout, signed range for ovf.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic m);
      longint ux, uy, sx, sy, u, t, lim;
      logic [W-1:0] r;
      logic cc, oo;
      ux  = longint'(x);
      uy  = longint'(y);
      lim = longint'(1) << (W - 1);
      sx  = x[W-1] ? ux - (lim << 1) : ux;
      sy  = y[W-1] ? uy - (lim << 1) : uy;
      if (m) begin
        u  = ux - uy;
        t  = sx - sy;
        cc = (ux >= uy);
      end else begin
        u  = ux + uy + longint'(c);
        t  = sx + sy + longint'(c);
        cc = ((u >> W) & 64'd1) != 0;
      end
      r  = u[W-1:0];
      oo = (t > lim - 1) || (t < -lim);
      return {oo, cc, r};
    endfunction

    always @(negedge clk) begin
      if (!rrst) begin
        chk($sformatf("cfg%0d in_ready", g), 64'(ir), 64'(!ov || ordy));
        if (stalled) begin
          chk($sformatf("cfg%0d stall_hold", g), 64'({of, co, s}), 64'(held));
          chk($sformatf("cfg%0d stall_valid", g), 64'(ov), 64'd1);
        end
        if (ov && ordy) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cfg%0d spurious_output: actual=%0h required=none", g, {of, co, s});
          end else begin
            chk($sformatf("cfg%0d result", g), 64'({of, co, s}), 64'(q.pop_front()));
          end
        end
        if (iv && ir) q.push_back(model(a, b, cin, sb));
        stalled <= ov && !ordy;
        held    <= {of, co, s};
      end
    end

    initial begin
      logic [31:0] rnd;
      wait (rrst == 1'b0);
      repeat (2500) begin
        @(posedge clk); #1;
        rnd  = $urandom;
        cin  = rnd[0];
        sb   = rnd[1];
        iv   = (rnd[3:2] != 2'b00);
        ordy = (rnd[5:4] != 2'b00);
        rnd  = $urandom;
        a    = rnd[W-1:0];
        rnd  = $urandom;
        b    = rnd[W-1:0];
      end
      @(posedge clk); #1;
      iv   = 1'b0;
      ordy = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      chk($sformatf("cfg%0d drained", g), 64'(q.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    logic all_done;
    d_rst = 1'b1; d_iv = 1'b0; d_or = 1'b1;
    d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    d_rst = 1'b0;
    rrst  = 1'b0;
    #1;
    chk("reset out_valid", 64'(d_ov), 64'd0);
    chk("reset sum",       64'(d_sum), 64'd0);
    chk("reset cout",      64'(d_cout), 64'd0);
    chk("reset ovf",       64'(d_ovf), 64'd0);
    chk("reset in_ready",  64'(d_ir), 64'd1);

    run_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_cin",    16'h0F0F, 16'h00F0, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back with a three-cycle output stall
    @(posedge clk); #1;
    d_iv = 1'b1; d_a = 16'd1; d_b = 16'd1; d_cin = 1'b0; d_sub = 1'b0; d_or = 1'b1;
    @(posedge clk); #1;
    d_a = 16'd2; d_b = 16'd2;
    @(posedge clk); #1;
    d_a = 16'd3; d_b = 16'd3;
    chk("b2b first_valid", 64'(d_ov), 64'd1);
    chk("b2b first_sum",   64'(d_sum), 64'h2);
    d_or = 1'b0;
    #1;
    chk("b2b stall_ready", 64'(d_ir), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b stall%0d sum", i),   64'(d_sum), 64'h2);
      chk($sformatf("b2b stall%0d valid", i), 64'(d_ov), 64'd1);
      chk($sformatf("b2b stall%0d ready", i), 64'(d_ir), 64'd0);
    end
    d_or = 1'b1;
    #1;
    chk("b2b release_sum",   64'(d_sum), 64'h2);
    chk("b2b release_ready", 64'(d_ir), 64'd1);
    @(posedge clk); #1;
    d_iv = 1'b0;
    chk("b2b second_sum", 64'(d_sum), 64'h4);
    chk("b2b second_valid", 64'(d_ov), 64'd1);
    @(posedge clk); #1;
    chk("b2b third_sum", 64'(d_sum), 64'h6);
    chk("b2b third_valid", 64'(d_ov), 64'd1);
    @(posedge clk); #1;
    chk("b2b empty", 64'(d_ov), 64'd0);

    // Reset with two operations in flight
    @(posedge clk); #1;
    d_iv = 1'b1; d_a = 16'd1; d_b = 16'd1;
    @(posedge clk); #1;
    d_a = 16'd2; d_b = 16'd2;
    @(posedge clk); #1;
    d_iv = 1'b0; d_rst = 1'b1;
    @(posedge clk); #1;
    d_rst = 1'b0;
    #1;
    chk("flush out_valid", 64'(d_ov), 64'd0);
    chk("flush sum",       64'(d_sum), 64'd0);
    chk("flush in_ready",  64'(d_ir), 64'd1);
    run_op("after_flush", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

    all_done = 1'b0;
    for (int i = 0; i < 20000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g_rand[0].done & g_rand[1].done & g_rand[2].done & g_rand[3].done;
    end
    if (!all_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL random_timeout: actual=not_done required=done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
